grf_multiport: RTL and testbench

Parametrised general register file for the pipelined CPU. It provides NUM_RD combinational read ports, NUM_WR clocked write ports and register 0 hardwired to zero. Optional write-to-read bypass is included. A per-register pending scoreboard lets the hazard unit stall on operands whose producer has issued but not yet written back. It sits in the decode stage: reads feed the operand muxes, writes come from writeback, and issue marks come from decode.

---
 rtl/grf_pkg.sv | 14 +
 rtl/grf_scoreboard.sv | 48 ++++
 rtl/grf_multiport.sv | 95 +++++++++
 tb/tb_grf_multiport.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared definitions for the general register file: default geometry, the
// hardwired zero register and the write-port index width helper.
package grf_pkg;

  localparam int GRF_DATA_W   = 32;
  localparam int GRF_ADDR_W   = 5;
  localparam int GRF_ZERO_REG = 0;

  // Width of an index selecting one of num_wr write ports (never below 1 bit).
  function automatic int grf_idx_w(input int num_wr);
    return (num_wr > 1) ? $clog2(num_wr) : 1;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set at issue, cleared by
// writeback or flush, with issue taking priority over both.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     flush,
  output logic [(1<<ADDR_W)-1:0]   pending
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pending_next;

  // Later assignments override earlier ones: flush, then writeback, then issue.
  always_comb begin
    pending_next = pending;
    if (flush) begin
      pending_next = '0;
    end
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k]) begin
        pending_next[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (iss_en) begin
      pending_next[iss_addr] = 1'b1;
    end
    pending_next[GRF_ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

endmodule

// File: rtl/grf_multiport.sv
// Multi-ported general register file with hardwired zero register, pending
// scoreboard and optional write-to-read bypass (enabled by GRF_BYPASS_EN).
module grf_multiport
  import grf_pkg::*;
#(
  parameter int DATA_W = GRF_DATA_W,
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(GRF_ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;

  // Non-blocking writes in port order, so the highest-numbered port wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] != ZERO_ADDR) begin
          regs[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  grf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .flush    (flush),
    .pending  (pending)
  );

`ifdef GRF_BYPASS_EN
  localparam int IDX_W = grf_idx_w(NUM_WR);
`endif

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] stored;

    assign a      = rd_addr[j*ADDR_W +: ADDR_W];
    assign stored = (a == ZERO_ADDR) ? '0 : regs[a];

`ifdef GRF_BYPASS_EN
    logic             hit;
    logic [IDX_W-1:0] hit_idx;

    // Scan ascending so the highest-numbered matching write port is forwarded.
    always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = 0; k < NUM_WR; k++) begin
        if (reset && a != ZERO_ADDR && wr_en[k] &&
            wr_addr[k*ADDR_W +: ADDR_W] == a) begin
          hit     = 1'b1;
          hit_idx = IDX_W'(k);
        end
      end
    end

    assign rd_data[j*DATA_W +: DATA_W] = hit ? wr_data[hit_idx*DATA_W +: DATA_W] : stored;
`else
    assign rd_data[j*DATA_W +: DATA_W] = stored;
`endif

    assign rd_pending[j] = pending[a];
  end

endmodule

// File: tb/tb_grf_multiport.sv
// Self-checking bench for grf_multiport: directed vector table, reset sweep and
// randomized traffic compared against an array-based register file model.
module tb_grf_multiport;

  logic        clk;
  logic        reset;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [14:0] rd_addr;
  logic [95:0] rd_data;
  logic [2:0]  rd_pending;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_reg  [32];
  bit          m_pend [32];

  typedef struct {
    logic        rst_n;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [14:0] ra;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] exp_nb;
    logic [31:0] exp_byp;
    logic        exp_pend;
  } vec_t;

  vec_t vecs[$];

  grf_multiport dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .iss_en     (iss_en),
    .iss_addr   (iss_addr),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic rst_n, input logic [1:0] we,
                               input int wa1, input int wa0,
                               input logic [31:0] wd1, input logic [31:0] wd0,
                               input logic ie, input int ia, input logic fl,
                               input int ra2, input int ra1, input int ra0);
    stim_t s;
    s.rst_n = rst_n;
    s.we    = we;
    s.wa    = {5'(wa1), 5'(wa0)};
    s.wd    = {wd1, wd0};
    s.ie    = ie;
    s.ia    = 5'(ia);
    s.fl    = fl;
    s.ra    = {5'(ra2), 5'(ra1), 5'(ra0)};
    return s;
  endfunction

  function automatic stim_t idle(input int ra2, input int ra1, input int ra0);
    return mk(1'b1, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0, 1'b0, ra2, ra1, ra0);
  endfunction

  task automatic addVec(input stim_t s, input logic [31:0] nb, input logic [31:0] byp,
                        input logic pend);
    vec_t v;
    v.s = s; v.exp_nb = nb; v.exp_byp = byp; v.exp_pend = pend;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference read: stored value, or newest same-cycle write when bypass is built in.
  function automatic logic [31:0] modelRead(input logic [4:0] a);
    logic [31:0] r;
    if (a == 5'd0) return 32'h0;
    r = m_reg[a];
`ifdef GRF_BYPASS_EN
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k] && wr_addr[k*5 +: 5] == a) r = wr_data[k*32 +: 32];
      end
    end
`endif
    return r;
  endfunction

  task automatic modelStep();
    bit written [32];
    logic [4:0] a;
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'h0;
        m_pend[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 32; i++) written[i] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        a = wr_addr[k*5 +: 5];
        if (wr_en[k]) begin
          written[a] = 1'b1;
          if (a != 5'd0) m_reg[a] = wr_data[k*32 +: 32];
        end
      end
      for (int i = 0; i < 32; i++) begin
        m_pend[i] = (m_pend[i] && !flush && !written[i]) ||
                    (iss_en && int'(iss_addr) == i && i != 0);
      end
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    reset    = s.rst_n;
    wr_en    = s.we;
    wr_addr  = s.wa;
    wr_data  = s.wd;
    iss_en   = s.ie;
    iss_addr = s.ia;
    flush    = s.fl;
    rd_addr  = s.ra;
    #1;
  endtask

  task automatic checkOutput();
    logic [4:0] a;
    for (int j = 0; j < 3; j++) begin
      a = rd_addr[j*5 +: 5];
      check($sformatf("rd_data[%0d] addr=%0d", j, a), rd_data[j*32 +: 32], modelRead(a));
      check($sformatf("rd_pending[%0d] addr=%0d", j, a), 32'(rd_pending[j]), 32'(m_pend[a]));
    end
  endtask

  task automatic tickCycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    stim_t s;
    logic [31:0] exp_d;

    // Power-up reset: registers are unknown until this edge, so nothing is compared yet.
    applyStimulus(mk(1'b0, 2'b00, 0, 0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 0, 0, 0));
    tickCycle();

    for (int a = 0; a < 32; a++) begin
      applyStimulus(idle(a, 31 - a, a));
      check($sformatf("reset_sweep data addr=%0d", a), rd_data[31:0], 32'h0);
      check($sformatf("reset_sweep pend addr=%0d", a), 32'(rd_pending[0]), 32'h0);
      checkOutput();
      tickCycle();
    end

    addVec(mk(1, 2'b11, 7, 7, 32'hBBBB, 32'hAAAA, 0, 0, 0, 7, 7, 7), 32'h0, 32'hBBBB, 0);
    addVec(idle(0, 7, 7), 32'hBBBB, 32'hBBBB, 0);
    addVec(mk(1, 2'b01, 0, 0, 32'h0, 32'h1234, 0, 0, 0, 0, 0, 0), 32'h0, 32'h0, 0);
    addVec(mk(1, 2'b00, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 0), 32'h0, 32'h0, 0);
    addVec(idle(0, 0, 0), 32'h0, 32'h0, 0);
    addVec(mk(1, 2'b00, 0, 0, 32'h0, 32'h0, 1, 16, 0, 16, 16, 16), 32'h0, 32'h0, 0);
    addVec(idle(16, 16, 16), 32'h0, 32'h0, 1);
    addVec(mk(1, 2'b01, 0, 16, 32'h0, 32'd3411, 0, 0, 0, 16, 16, 16), 32'h0, 32'd3411, 1);
    addVec(idle(16, 16, 16), 32'd3411, 32'd3411, 0);
    addVec(mk(1, 2'b10, 9, 0, 32'h99, 32'h0, 1, 9, 0, 9, 9, 9), 32'h0, 32'h99, 0);
    addVec(mk(1, 2'b00, 0, 0, 32'h0, 32'h0, 1, 12, 0, 12, 9, 9), 32'h99, 32'h99, 1);
    addVec(mk(1, 2'b00, 0, 0, 32'h0, 32'h0, 1, 5, 1, 5, 12, 12), 32'h0, 32'h0, 1);
    addVec(idle(12, 9, 5), 32'h0, 32'h0, 1);
    addVec(idle(5, 12, 9), 32'h99, 32'h99, 0);
    addVec(idle(9, 5, 12), 32'h0, 32'h0, 0);
    addVec(mk(1, 2'b01, 0, 15, 32'h0, 32'h55, 1, 15, 0, 15, 15, 15), 32'h0, 32'h55, 0);
    addVec(mk(0, 2'b01, 0, 15, 32'h0, 32'h66, 1, 20, 0, 15, 15, 15), 32'h55, 32'h55, 1);
    addVec(idle(20, 16, 15), 32'h0, 32'h0, 0);
    addVec(idle(9, 5, 20), 32'h0, 32'h0, 0);

    foreach (vecs[i]) begin
`ifdef GRF_BYPASS_EN
      exp_d = vecs[i].exp_byp;
`else
      exp_d = vecs[i].exp_nb;
`endif
      applyStimulus(vecs[i].s);
      check($sformatf("vec%0d rd_data[0]", i), rd_data[31:0], exp_d);
      check($sformatf("vec%0d rd_pending[0]", i), 32'(rd_pending[0]), 32'(vecs[i].exp_pend));
      checkOutput();
      tickCycle();
    end

    // Randomized traffic on a narrow address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      s = mk(($urandom_range(39) != 0), 2'($urandom_range(3)),
             $urandom_range(7), $urandom_range(7), $urandom, $urandom,
             ($urandom_range(2) == 0), $urandom_range(7), ($urandom_range(9) == 0),
             $urandom_range(7), $urandom_range(7), $urandom_range(7));
      applyStimulus(s);
      checkOutput();
      tickCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
